// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 host link: FSM state encoding, frame
//   constants and the odd-parity helper. Imported by ps2_host_tx and reusable
//   by the receive side.
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } ps2_state_e;

   // Start-bit hold time with the clock still inhibited, in clk cycles.
   localparam int REQ_CYCLES      = 8;
   // Device clock falls in one host-to-device frame (8 data, parity, stop, ack).
   localparam int FALLS_PER_FRAME = 11;

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
//   Conditions one raw PS/2 pin: 2-FF synchronizer, then a glitch filter that
//   only accepts a new level after FILTER_LEN consecutive equal samples, then
//   a falling-edge detector on the accepted level.
//
//   Ports
//     clk, rst  : system clock, asynchronous active-high reset
//     line_in   : raw pin level (asynchronous to clk)
//     level     : filtered level (resets high, the idle level of the bus)
//     fall      : one-cycle pulse when the filtered level goes 1 -> 0
//
//   Latency: a raw edge shows on level/fall 2+FILTER_LEN cycles later.
// -----------------------------------------------------------------------------
module ps2_line_sync #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic fall
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          fall_q,  fall_d;
   logic [FW-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = line_in;
      sync2_d = sync1_q;
      level_d = level_q;
      fall_d  = 1'b0;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         // Any sample agreeing with the current level restarts the run.
         cnt_d = '0;
      end else if (cnt_q == FW'(FILTER_LEN - 1)) begin
         // This is the FILTER_LEN-th differing sample in a row: accept it.
         level_d = sync2_q;
         fall_d  = level_q & ~sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + FW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the device over
//   the open-collector clock/data pair: inhibit the clock, assert the start
//   bit, release the clock, then shift data, odd parity and stop on each
//   device clock fall, and finally sample the device ACK.
//
//   Ports
//     clk, rst          : system clock, asynchronous active-high reset
//     tx_data[7:0]      : byte to send, latched when tx_start is accepted
//     tx_start          : one-cycle request, accepted only when idle
//     tx_busy           : high from the cycle after acceptance until idle
//     tx_done           : one-cycle pulse at the end of every transaction
//     tx_error          : qualifies tx_done; 1 = no ACK or watchdog timeout
//     ps2_clk_in/dat_in : raw pin levels
//     ps2_clk_oe/dat_oe : 1 = pull the corresponding line low
//     dbg_state[2:0]    : current FSM state (ps2_state_e encoding)
//
//   Handshake: tx_start is a single-cycle strobe sampled only in IDLE; it is
//   accepted exactly when tx_busy is low, and tx_done/tx_error close the
//   transaction in the same cycle tx_busy drops. All outputs are registered.
// -----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int FILTER_LEN     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic [2:0] dbg_state
);

   // One counter times both the inhibit and the start-bit phases.
   localparam int CNT_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int WW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic clk_level, clk_fall;
   logic dat_level, dat_fall_unused;

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_clk_in),
      .level   (clk_level),
      .fall    (clk_fall)
   );

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_dat_in),
      .level   (dat_level),
      .fall    (dat_fall_unused)
   );

   ps2_state_e    state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [3:0]    fall_cnt_q, fall_cnt_d;
   logic [WW-1:0] wd_q,       wd_d;
   logic [7:0]    data_q,     data_d;
   logic          parity_q,   parity_d;
   logic          ack_q,      ack_d;
   logic          clk_oe_q,   clk_oe_d;
   logic          dat_oe_q,   dat_oe_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;
   logic          err_q,      err_d;
   logic          wd_expired;

   assign wd_expired = (wd_q == WW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fall_cnt_d = fall_cnt_q;
      wd_d       = wd_q;
      data_d     = data_q;
      parity_d   = parity_q;
      ack_d      = ack_q;
      clk_oe_d   = clk_oe_q;
      dat_oe_d   = dat_oe_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            if (tx_start) begin
               data_d     = tx_data;
               parity_d   = odd_parity(tx_data);
               ack_d      = 1'b0;
               cnt_d      = '0;
               fall_cnt_d = '0;
               clk_oe_d   = 1'b1;
               busy_d     = 1'b1;
               state_d    = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
               cnt_d    = '0;
               dat_oe_d = 1'b1;   // start bit, clock still held low
               state_d  = ST_REQ;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_REQ: begin
            if (cnt_q == CW'(REQ_CYCLES - 1)) begin
               cnt_d      = '0;
               clk_oe_d   = 1'b0; // hand the clock to the device
               wd_d       = '0;
               fall_cnt_d = '0;
               state_d    = ST_SEND;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_SEND: begin
            if (wd_expired) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               err_d    = 1'b1;
               state_d  = ST_IDLE;
            end else if (clk_fall) begin
               wd_d       = '0;
               fall_cnt_d = fall_cnt_q + 4'd1;
               // fall_cnt_q is the count before this fall, so it indexes the
               // data bit directly for falls 1..8.
               if (fall_cnt_q < 4'd8) begin
                  dat_oe_d = ~data_q[fall_cnt_q[2:0]];
               end else if (fall_cnt_q == 4'd8) begin
                  dat_oe_d = ~parity_q;
               end else if (fall_cnt_q == 4'd9) begin
                  dat_oe_d = 1'b0;  // stop bit: release the line
               end else begin
                  // Host already released data, so the level is the device ACK.
                  ack_d   = ~dat_level;
                  state_d = ST_WAIT_IDLE;
               end
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end

         ST_WAIT_IDLE: begin
            if (wd_expired) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               err_d    = 1'b1;
               state_d  = ST_IDLE;
            end else if (clk_level && dat_level) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               err_d   = ~ack_q;
               state_d = ST_IDLE;
            end else if (clk_fall) begin
               wd_d = '0;
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end

         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         fall_cnt_q <= '0;
         wd_q       <= '0;
         data_q     <= '0;
         parity_q   <= 1'b0;
         ack_q      <= 1'b0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fall_cnt_q <= fall_cnt_d;
         wd_q       <= wd_d;
         data_q     <= data_d;
         parity_q   <= parity_d;
         ack_q      <= ack_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign tx_busy    = busy_q;
   assign tx_done    = done_q;
   assign tx_error   = err_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx with a simple PS/2 device model on a
//   wired-AND bus. Frames seen on the wire are compared against hand-computed
//   {stop, parity, data} words held in an expected queue.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

   localparam int INHIBIT = 100;
   localparam int TIMEOUT = 3000;
   localparam int FILT    = 4;
   localparam int HALF    = 20;   // device clock half period, in clk cycles

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic [2:0] dbg_state;

   logic       dev_clk;
   logic       dev_dat;

   int n_checks;
   int n_errors;

   logic [9:0] exp_q[$];

   // Open-collector bus: either side can pull a line low.
   assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
   assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INHIBIT),
      .TIMEOUT_CYCLES (TIMEOUT),
      .FILTER_LEN     (FILT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .dbg_state  (dbg_state)
   );

   // ---------------------------------------------------------------- clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // ---------------------------------------------------------------- checking
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   // Caller is at a negedge; tx_start is seen at the next posedge.
   task automatic start_tx(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   // Measure the inhibit/request phase from the first cycle of tx_busy.
   task automatic measure_request();
      int cyc;
      int clk_hi;
      int dat_rise;
      cyc      = 1;
      clk_hi   = 0;
      dat_rise = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!ps2_clk_oe) break;
         clk_hi++;
         if (ps2_dat_oe && dat_rise == 0) dat_rise = cyc;
         @(negedge clk);
         cyc++;
      end
      check("clk_oe_width", clk_hi, INHIBIT + 8);
      check("dat_oe_rise",  dat_rise, INHIBIT + 1);
   endtask

   // Device model: clocks nfalls pulses, samples data on each rising edge and,
   // after the stop bit, pulls data low for the ACK if ack is set.
   task automatic dev_frame(input logic ack, input int nfalls, output logic [9:0] bits);
      bits = '0;
      for (int i = 0; i < 200; i++) begin
         if (!ps2_clk_oe && ps2_dat_oe) break;
         @(negedge clk);
      end
      check("send_entry", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
      repeat (10) @(negedge clk);
      check("start_bit", ps2_dat_in, 1'b0);
      for (int i = 1; i <= nfalls; i++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (i <= 10) bits[i-1] = ps2_dat_in;
         dev_clk = 1'b1;
         if (i == 11) begin
            dev_dat = 1'b1;
         end else if (i == 10) begin
            repeat (5) @(negedge clk);
            dev_dat = ~ack;
            repeat (HALF - 5) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
      end
   endtask

   task automatic wait_done(input string tag, input logic exp_err);
      for (int i = 0; i < 2000; i++) begin
         if (tx_done) break;
         @(negedge clk);
      end
      check({tag, "_done"},  tx_done,  1'b1);
      check({tag, "_err"},   tx_error, exp_err);
      check({tag, "_busy"},  tx_busy,  1'b0);
      check({tag, "_oe"},    {ps2_clk_oe, ps2_dat_oe}, 2'b00);
   endtask

   // Full transaction; poke issues a second tx_start during SEND.
   task automatic send_frame(input string tag, input logic [7:0] d, input logic ack,
                             input logic poke);
      logic [9:0] bits;
      logic [9:0] exp;
      start_tx(d);
      check({tag, "_accept"}, {tx_busy, ps2_clk_oe}, 2'b11);
      measure_request();
      if (poke) begin
         tx_data  = 8'h12;
         tx_start = 1'b1;
         @(negedge clk);
         tx_start = 1'b0;
         tx_data  = d;
         check({tag, "_poke_state"}, {tx_busy, dbg_state}, {1'b1, 3'd3});
      end
      dev_frame(ack, 11, bits);
      exp = exp_q.pop_front();
      check({tag, "_frame"}, bits, exp);
      wait_done(tag, ~ack);
   endtask

   // ---------------------------------------------------------------- main
   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      tx_data  = 8'h00;
      tx_start = 1'b0;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;

      // {stop, parity, data}; parity makes the count of ones odd.
      exp_q.push_back(10'h3ED);   // 0xED: six ones  -> parity 1
      exp_q.push_back(10'h2F4);   // 0xF4: five ones -> parity 0
      exp_q.push_back(10'h300);   // 0x00: no ones   -> parity 1
      exp_q.push_back(10'h3AA);   // 0xAA: four ones -> parity 1 (NACK case)
      exp_q.push_back(10'h3FF);   // 0xFF: eight ones -> parity 1

      repeat (3) @(negedge clk);
      check("reset_outputs",
            {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe, dbg_state}, 8'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_outputs", {tx_busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);

      send_frame("ed", 8'hED, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      send_frame("f4", 8'hF4, 1'b1, 1'b1);
      // Back-to-back: start in the cycle right after tx_done.
      @(negedge clk);
      send_frame("z0", 8'h00, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      send_frame("nack", 8'hAA, 1'b0, 1'b0);
      repeat (5) @(negedge clk);

      // Device never clocks: watchdog fires TIMEOUT cycles after SEND entry.
      begin
         int cnt;
         start_tx(8'h5A);
         for (int i = 0; i < 2000; i++) begin
            if (!ps2_clk_oe) break;
            @(negedge clk);
         end
         cnt = 0;
         for (int i = 0; i < TIMEOUT + 100; i++) begin
            if (tx_done) break;
            @(negedge clk);
            cnt++;
         end
         check("wd_cycles", cnt, TIMEOUT);
         check("wd_done_err", {tx_done, tx_error}, 2'b11);
         check("wd_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
         @(negedge clk);
         check("wd_done_pulse", tx_done, 1'b0);
      end
      repeat (5) @(negedge clk);

      // Reset mid-frame after fall 5; bit 4 of 0xA5 is 0 so data is pulled low.
      begin
         logic [9:0] bits;
         start_tx(8'hA5);
         measure_request();
         dev_frame(1'b1, 5, bits);
         check("rst_pre_dat_oe", ps2_dat_oe, 1'b1);
         rst = 1'b1;
         #1;
         check("rst_async_oe", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 3'b000);
         @(negedge clk);
         rst = 1'b0;
         repeat (3) @(negedge clk);
      end

      send_frame("ff", 8'hFF, 1'b1, 1'b0);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send direction of the keyboard link, the counterpart of `ps2_keyboard`, which only receives. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the device. Signalling is open-collector on the shared `ps2_clk1`/`ps2_dat1` inout pins. The block runs on `global_clk` (50 MHz). The top level drives each pin low when its `*_oe` output is high, otherwise `1'bz`. The top level also gates `ps2_keyboard` while `tx_busy` is high.

## Interface
- `INHIBIT_CYCLES`, default 6000: clock-inhibit duration in clk cycles (120 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1_000_000: maximum gap between device clock falls (20 ms).
- `FILTER_LEN`, default 4: consecutive equal samples required before a line level is accepted.
- `clk`  in  1  system clock (`global_clk`). One clock domain only.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to send; latched on an accepted `tx_start`.
- `tx_start`  in  1  one-cycle request; accepted only in IDLE.
- `tx_busy`  out  1  high from the cycle after acceptance until the return to IDLE.
- `tx_done`  out  1  one-cycle pulse when a transaction ends, by success or failure.
- `tx_error`  out  1  valid with `tx_done`: 1 = no ACK or timeout.
- `ps2_clk_in`, `ps2_dat_in`  in  1  raw pin levels.
- `ps2_clk_oe`, `ps2_dat_oe`  out  1  1 = pull the line low.

## Operation
- Inputs pass through `ps2_line_sync`: a 2-FF synchronizer, then a FILTER_LEN filter. It outputs a filtered level and a one-cycle `fall` pulse.
- Odd parity: parity bit = `~^tx_data`.
- State machine:
  - IDLE: both `oe` low. On `tx_start`, latch the data and parity, go to INHIBIT.
  - INHIBIT: `clk_oe`=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: `clk_oe`=1 and `dat_oe`=1 (start bit) for REQ_CYCLES = 8 cycles, then go to SEND.
  - SEND: `clk_oe`=0, `dat_oe` held at 1. Each filtered `fall` increments `fall_cnt` (1..11):
    - falls 1–8: drive data bit `fall_cnt-1`, LSB first (`dat_oe` = ~bit).
    - fall 9: drive the parity bit.
    - fall 10: release data (stop bit = 1).
    - fall 11: sample `dat`. Low = ACK. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until the filtered `clk` and `dat` are both high. Then pulse `tx_done` with `tx_error` = ~ACK, and go to IDLE.
- Watchdog: a counter clears on entry to SEND and on every `fall`. It runs only in SEND and WAIT_IDLE. If it reaches TIMEOUT_CYCLES:
  - both `oe` go low;
  - `tx_done`=1 and `tx_error`=1 for one cycle;
  - the block returns to IDLE.
- `tx_start` while busy is ignored and does not alter the latched byte.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0. Reset is asynchronous, so an in-flight transfer releases both lines immediately on `rst`.
- All outputs are registered.
- `tx_start` at cycle N gives `tx_busy`=1 and `clk_oe`=1 at N+1.
- `clk_oe` stays high for exactly INHIBIT_CYCLES+REQ_CYCLES cycles. `dat_oe` rises INHIBIT_CYCLES cycles after `clk_oe`.
- `dat_oe` changes in the cycle after the filtered `fall` pulse. That is 3+FILTER_LEN cycles after the raw edge, well inside the device's ~40 µs half-period.
- The ACK is sampled on the same cycle as the 11th `fall` pulse.
- `tx_done` rises in the cycle `tx_busy` falls. A new `tx_start` is accepted in the cycle after `tx_done`.
- A `fall` outside SEND and the watchdog is ignored.

## Structure
- Shared package `ps2_pkg`:
  - state encoding (IDLE, INHIBIT, REQ, SEND, WAIT_IDLE);
  - REQ_CYCLES=8, FALLS_PER_FRAME=11;
  - the parity function.
- Sub-module `ps2_line_sync`: synchronizer, filter and fall detect. Instantiated twice here, once per line. Reusable by `ps2_keyboard`.

## Test plan
- Send 0xED; the device model clocks 11 falls and ACKs. Required `dat` sequence after the start bit: 1,0,1,1,0,1,1,1, parity 1, stop 1. Then `tx_done`=1 with `tx_error`=0.
- Send 0xF4 → parity bit 0. Send 0x00 → eight 0 bits, parity 1. Both complete without error.
- The device leaves `dat` high at fall 11 → `tx_done`=1, `tx_error`=1. `tx_busy` drops once both lines are high.
- The device never clocks after REQ → after exactly TIMEOUT_CYCLES: `tx_done`=1, `tx_error`=1, both `oe`=0.
- With INHIBIT_CYCLES=100:
  - `clk_oe` is high for 108 cycles;
  - `dat_oe` rises at cycle 101;
  - a second `tx_start` during SEND is ignored, and the byte on the wire stays the first one.
- Assert `rst` after fall 5 → both `oe` are 0 in the same cycle. A following transfer of 0xFF succeeds.
